// File: rtl/z_trade_order_ctrl.sv
// Order-sequencing controller behind the Z-score trade decision unit.
// It gates decisions behind a warm-up period and issues one order at a time against a symmetric position limit.
module z_trade_order_ctrl #(
    parameter int WARMUP_SAMPLES  = 16,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int MAX_POS         = 4,
    parameter int POS_W           = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic                    buy_signal,
    input  logic                    sell_signal,
    input  logic                    flush,
    input  logic                    order_ready,
    output logic                    order_valid,
    output logic                    order_side,
    output logic signed [POS_W-1:0] position,
    output logic                    armed,
    output logic                    reject
);

    typedef enum logic [1:0] {
        WARMUP,
        IDLE,
        ISSUE,
        COOLDOWN
    } state_t;

    localparam logic signed [POS_W-1:0] POS_HI  = POS_W'(MAX_POS);
    localparam logic signed [POS_W-1:0] POS_LO  = -POS_HI;
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [7:0] WARM_LAST = 8'(WARMUP_SAMPLES - 1);
    localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_CYCLES);

    state_t     state;
    logic [7:0] warm_cnt;
    logic [7:0] cool_cnt;

    // A handshake can only happen in ISSUE, where order_valid is already high.
    logic handshake;
    assign handshake = (state == ISSUE) && order_ready;

    // NOTE: every register is written with <= so all state updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WARMUP;
            warm_cnt    <= '0;
            cool_cnt    <= '0;
            order_valid <= 1'b0;
            order_side  <= 1'b0;
            position    <= '0;
            armed       <= 1'b0;
            reject      <= 1'b0;
        end else begin
            reject <= 1'b0;
            if (flush) begin
                state       <= WARMUP;
                warm_cnt    <= '0;
                cool_cnt    <= '0;
                order_valid <= 1'b0;
                armed       <= 1'b0;
                if (handshake) begin
                    position <= order_side ? position - POS_ONE : position + POS_ONE;
                end
            end else begin
                case (state)
                    WARMUP: begin
                        if (sample_valid) begin
                            if (warm_cnt != 8'hFF) begin
                                warm_cnt <= warm_cnt + 8'd1;
                            end
                            if (warm_cnt == WARM_LAST) begin
                                state <= IDLE;
                                armed <= 1'b1;
                            end
                        end
                    end
                    IDLE: begin
                        if (sample_valid) begin
                            case ({buy_signal, sell_signal})
                                2'b10: begin
                                    if (position < POS_HI) begin
                                        order_side  <= 1'b0;
                                        order_valid <= 1'b1;
                                        state       <= ISSUE;
                                    end else begin
                                        reject <= 1'b1;
                                    end
                                end
                                2'b01: begin
                                    if (position > POS_LO) begin
                                        order_side  <= 1'b1;
                                        order_valid <= 1'b1;
                                        state       <= ISSUE;
                                    end else begin
                                        reject <= 1'b1;
                                    end
                                end
                                2'b11:   reject <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                    ISSUE: begin
                        if (order_ready) begin
                            position    <= order_side ? position - POS_ONE : position + POS_ONE;
                            order_valid <= 1'b0;
                            if (COOL_LOAD == 8'd0) begin
                                state <= IDLE;
                            end else begin
                                state    <= COOLDOWN;
                                cool_cnt <= COOL_LOAD;
                            end
                        end
                    end
                    COOLDOWN: begin
                        cool_cnt <= cool_cnt - 8'd1;
                        if (cool_cnt == 8'd1) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= WARMUP;
                endcase
            end
        end
    end

endmodule

// File: doc/z_trade_order_ctrl.md
# z_trade_order_ctrl

Order-sequencing controller placed after the Z-score trade decision unit. It gates that unit's buy/sell decisions behind a warm-up period, turns accepted decisions into single orders on a valid/ready handshake, and tracks the resulting net position against a symmetric limit. It also enforces a cooldown after every filled order, so the downstream order interface sees at most one outstanding order.

## Interface
Parameters:
- WARMUP_SAMPLES, 16: number of valid samples that must be seen before any decision is acted on (1..255).
- COOLDOWN_CYCLES, 8: clock cycles during which decisions are ignored after each order handshake (0..255).
- MAX_POS, 4: absolute net-position limit in order units (1..2^(POS_W-1)-1).
- POS_W, 8: width of the signed position counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  high for one cycle when a new price sample has been processed; buy_signal/sell_signal qualify only in this cycle.
- buy_signal  in  1  registered buy decision from the Z-score unit.
- sell_signal  in  1  registered sell decision from the Z-score unit.
- flush  in  1  synchronous re-arm request: restart warm-up and abandon any pending order.
- order_ready  in  1  downstream accepts the order when high together with order_valid.
- order_valid  out  1  order pending.
- order_side  out  1  0 = buy, 1 = sell; stable while order_valid is high.
- position  out  POS_W  signed net position (buys minus sells), two's complement.
- armed  out  1  high when warm-up is complete (state is not WARMUP).
- reject  out  1  one-cycle pulse when a qualified decision is dropped by a position limit or a buy/sell conflict.

## Operation
FSM states: WARMUP, IDLE, ISSUE, COOLDOWN. Reset state is WARMUP.
- WARMUP
  - A saturating 8-bit counter increments on each sample_valid.
  - On the sample_valid that brings the count to WARMUP_SAMPLES, the next state is IDLE.
  - The decision on that completing sample is ignored.
  - All decisions in WARMUP are ignored and do not pulse reject.
- IDLE, on a cycle with sample_valid = 1:
  - Buy only: if position < MAX_POS, latch side = 0 and go to ISSUE; otherwise pulse reject and stay in IDLE.
  - Sell only: if position > -MAX_POS, latch side = 1 and go to ISSUE; otherwise pulse reject and stay in IDLE.
  - Buy and sell both high: conflict; pulse reject and stay in IDLE.
  - Neither high: stay in IDLE.
- IDLE with sample_valid = 0: buy_signal and sell_signal are ignored.
- ISSUE
  - order_valid = 1 and order_side holds the latched side.
  - Incoming decisions are ignored without pulsing reject.
  - On a cycle with order_valid and order_ready both high:
    - position changes by +1 (buy) or -1 (sell) at that clock edge.
    - The next state is COOLDOWN with the counter loaded to COOLDOWN_CYCLES, or IDLE if COOLDOWN_CYCLES = 0.
- COOLDOWN
  - The counter decrements every clock cycle.
  - When the counter is 1, the next state is IDLE.
  - Decisions are ignored without pulsing reject.
- flush (priority over all transitions except reset)
  - Next state is WARMUP and the warm-up counter is cleared.
  - The cooldown counter is cleared and order_valid drops on the next cycle.
  - If flush coincides with an ISSUE handshake, the handshake still completes and position updates.
  - Position is otherwise retained.
- Position arithmetic is signed POS_W and never leaves [-MAX_POS, MAX_POS]. Wrap-around is impossible because the limit check precedes issue.
- Reset (asynchronous) values: order_valid = 0, order_side = 0, position = 0, armed = 0, reject = 0, all counters 0, state WARMUP.

## Timing
- All outputs are registered.
- An accepted decision at the edge closing cycle t gives order_valid = 1 in cycle t+1. This is the minimum latency.
- reject is high in cycle t+1 only, for a decision in cycle t.
- A handshake in cycle h gives:
  - position updated and order_valid = 0 from cycle h+1.
  - With COOLDOWN_CYCLES = C > 0, COOLDOWN occupies cycles h+1 .. h+C, and the earliest new decision is accepted in cycle h+C+1.
- armed rises in the cycle after the completing warm-up sample.
- armed falls in the cycle after flush.
- order_valid is never deasserted without a handshake, except by flush or reset.
- Back-pressure is unbounded: ISSUE is held for as long as order_ready stays low.

## Test plan
- Reset, then 15 sample_valid pulses with buy_signal = 1 -> no order and armed = 0. 16th pulse -> armed = 1 next cycle, still no order.
- Armed, order_ready = 1, buy on a sample at cycle t -> order_valid = 1 with side 0 at t+1, position = 1 at t+2. A buy at t+2..t+9 (cooldown, C = 8) is ignored. A buy at t+10 is accepted.
- order_ready held low for 20 cycles during ISSUE -> order_valid and order_side stable throughout; position changes only after order_ready rises.
- Four accepted buys (position = 4), then a fifth buy -> reject pulse, no order. Then a sell -> order with side 1, position = 3.
- buy_signal and sell_signal both high on a sample in IDLE -> reject pulse, no order, position unchanged.
- flush during ISSUE with order_ready = 0 -> order_valid = 0 next cycle, armed = 0, position unchanged, and 16 new samples needed before the next order. Asynchronous rst mid-cooldown -> all outputs return to their reset values immediately.
